// File: rtl/hqm_aw_cfg_req_arb.sv
// Config request arbiter: shares one core cfg target between NUM_REQ requesters.
// One transaction is outstanding at a time. Responses are routed back to the owner.
// A watchdog returns a zero timeout response when the target never acknowledges.

package hqm_aw_cfg_req_arb_pkg;
  typedef struct packed {
    logic [27:0] addr;
    logic [31:0] wdata;
  } cfg_req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } cfg_rsp_t;
endpackage

module hqm_aw_cfg_req_arb
  import hqm_aw_cfg_req_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_prep,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ-1:0]    req_read,
  input  cfg_req_t [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0]    req_gnt,
  output logic [NUM_REQ-1:0]    rsp_ack,
  output logic [NUM_REQ-1:0]    rsp_timeout,
  output cfg_rsp_t              rsp,
  output logic                  core_cfg_req_write,
  output logic                  core_cfg_req_read,
  output cfg_req_t              core_cfg_req,
  input  logic                  core_cfg_rsp_ack,
  input  cfg_rsp_t              core_cfg_rsp,
  output logic                  err_unexp_ack,
  output logic                  cfg_idle
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   win_reg, win_next;
  logic [IDX_W-1:0]   last_gnt_reg, last_gnt_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  cfg_req_t           pay_reg, pay_next;
  cfg_rsp_t           rsp_reg, rsp_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [NUM_REQ-1:0] tmo_reg, tmo_next;
  logic               cwr_reg, cwr_next;
  logic               crd_reg, crd_next;
  logic               err_reg, err_next;

  logic [NUM_REQ-1:0] req_valid;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;

  // A requester is valid with either a write or a read level asserted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_valid
    assign req_valid[gi] = req_write[gi] | req_read[gi];
  end

  // Round-robin pick: first valid requester searching upward from last_gnt+1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_gnt_reg;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!rr_found && req_valid[(int'(last_gnt_reg) + k) % NUM_REQ]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(last_gnt_reg) + k) % NUM_REQ);
      end
    end
  end

  // Next-state and next-output decode; output pulses are registered so they come from flops.
  always_comb begin
    state_next    = state_reg;
    win_next      = win_reg;
    last_gnt_next = last_gnt_reg;
    cnt_next      = cnt_reg;
    pay_next      = pay_reg;
    rsp_next      = rsp_reg;
    gnt_next      = '0;
    ack_next      = '0;
    tmo_next      = '0;
    cwr_next      = 1'b0;
    crd_next      = 1'b0;
    err_next      = 1'b0;
    if (rst_prep) begin
      // Abort whatever is in flight; the owner gets no response, last_gnt survives.
      state_next = IDLE;
      cnt_next   = '0;
      pay_next   = '0;
    end else begin
      // Any ack outside WAIT (including one after a timeout) is stray.
      err_next = core_cfg_rsp_ack && (state_reg != WAIT);
      case (state_reg)
        IDLE: begin
          if (rr_found) begin
            state_next       = ISSUE;
            win_next         = rr_idx;
            pay_next         = req[rr_idx];
            gnt_next[rr_idx] = 1'b1;
            // Write takes precedence when both levels are set.
            cwr_next         = req_write[rr_idx];
            crd_next         = ~req_write[rr_idx];
          end
        end
        ISSUE: begin
          state_next    = WAIT;
          cnt_next      = '0;
          last_gnt_next = win_reg;
        end
        WAIT: begin
          if (core_cfg_rsp_ack) begin
            // Ack beats a timeout landing in the same cycle.
            state_next        = RESP;
            rsp_next          = core_cfg_rsp;
            ack_next[win_reg] = 1'b1;
          end else if (cnt_reg == CNT_MAX) begin
            state_next        = RESP;
            rsp_next          = '0;
            ack_next[win_reg] = 1'b1;
            tmo_next[win_reg] = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RESP: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      win_reg      <= '0;
      last_gnt_reg <= LAST_RST;
      cnt_reg      <= '0;
      pay_reg      <= '0;
      rsp_reg      <= '0;
      gnt_reg      <= '0;
      ack_reg      <= '0;
      tmo_reg      <= '0;
      cwr_reg      <= 1'b0;
      crd_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      win_reg      <= win_next;
      last_gnt_reg <= last_gnt_next;
      cnt_reg      <= cnt_next;
      pay_reg      <= pay_next;
      rsp_reg      <= rsp_next;
      gnt_reg      <= gnt_next;
      ack_reg      <= ack_next;
      tmo_reg      <= tmo_next;
      cwr_reg      <= cwr_next;
      crd_reg      <= crd_next;
      err_reg      <= err_next;
    end
  end

  assign req_gnt            = rst_prep ? '0   : gnt_reg;
  assign rsp_ack            = rst_prep ? '0   : ack_reg;
  assign rsp_timeout        = rst_prep ? '0   : tmo_reg;
  assign rsp                = rst_prep ? '0   : rsp_reg;
  assign core_cfg_req_write = rst_prep ? 1'b0 : cwr_reg;
  assign core_cfg_req_read  = rst_prep ? 1'b0 : crd_reg;
  assign core_cfg_req       = rst_prep ? '0   : pay_reg;
  assign err_unexp_ack      = rst_prep ? 1'b0 : err_reg;
  assign cfg_idle           = (state_reg == IDLE) && !(|req_valid);

endmodule
